// File: rtl/icache_fill_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : icache_fill_ctrl
// Purpose  : Direct-mapped L1 instruction cache with in-order line fill,
//            flush invalidate and saturating hit/miss counters.
// Revision : 1.0
// ============================================================================
module icache_fill_ctrl #(
  parameter int ADDR_WIDTH = 14,
  parameter int LINE_WORDS = 4,
  parameter int NUM_LINES  = 16,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  MEM_CLK,
  input  logic                  RST,
  input  logic                  MEM_RDEN1,
  input  logic [ADDR_WIDTH-1:0] MEM_ADDR1,
  input  logic                  FLUSH,
  output logic [31:0]           MEM_DOUT1,
  output logic                  memValid1,
  output logic                  busy,
  output logic                  mm_re,
  output logic [ADDR_WIDTH-1:0] mm_addr,
  input  logic [31:0]           mm_data,
  input  logic                  mm_valid,
  output logic [CNT_WIDTH-1:0]  hit_cnt,
  output logic [CNT_WIDTH-1:0]  miss_cnt
);

  localparam int c_OFF = $clog2(LINE_WORDS);
  localparam int c_IDX = $clog2(NUM_LINES);
  localparam int c_TAG = ADDR_WIDTH - c_OFF - c_IDX;
  localparam logic [c_OFF-1:0] c_LAST = c_OFF'(LINE_WORDS - 1);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_FILL = 1'b1
  } state_t;

  state_t                r_state;
  logic [31:0]           r_data [NUM_LINES*LINE_WORDS];
  logic [c_TAG-1:0]      r_tag  [NUM_LINES];
  logic [NUM_LINES-1:0]  r_valid;
  logic [c_IDX-1:0]      r_idx;
  logic [c_TAG-1:0]      r_ltag;
  logic [c_OFF-1:0]      r_cnt;
  logic                  r_flush_pend;
  logic [ADDR_WIDTH-1:0] r_mm_addr;
  logic                  r_busy;
  logic [CNT_WIDTH-1:0]  r_hit_cnt;
  logic [CNT_WIDTH-1:0]  r_miss_cnt;

  logic [c_OFF-1:0]      w_off;
  logic [c_IDX-1:0]      w_idx;
  logic [c_TAG-1:0]      w_tag;
  logic                  w_hit;
  logic                  w_start;
  logic                  w_wr;
  logic                  w_last;

  assign w_off   = MEM_ADDR1[c_OFF-1:0];
  assign w_idx   = MEM_ADDR1[c_OFF+c_IDX-1:c_OFF];
  assign w_tag   = MEM_ADDR1[ADDR_WIDTH-1:c_OFF+c_IDX];
  assign w_hit   = (r_state == S_IDLE) && MEM_RDEN1 && !FLUSH &&
                   r_valid[w_idx] && (r_tag[w_idx] == w_tag);
  assign w_start = (r_state == S_IDLE) && MEM_RDEN1 && !FLUSH && !w_hit;
  assign w_wr    = (r_state == S_FILL) && mm_valid;
  assign w_last  = w_wr && (r_cnt == c_LAST);

  assign memValid1 = w_hit;
  assign MEM_DOUT1 = w_hit ? r_data[{w_idx, w_off}] : 32'hDEAD_BEEF;
  assign busy      = r_busy;
  assign mm_re     = r_busy;
  assign mm_addr   = r_mm_addr;
  assign hit_cnt   = r_hit_cnt;
  assign miss_cnt  = r_miss_cnt;

  // Storage arrays carry no reset so they can map onto RAM; valid bits gate them.
  always_ff @(posedge MEM_CLK) begin
    if (!RST && w_wr) r_data[{r_idx, r_cnt}] <= mm_data;
    if (!RST && w_last) r_tag[r_idx] <= r_ltag;
  end

  always_ff @(posedge MEM_CLK) begin
    if (RST) begin
      r_state      <= S_IDLE;
      r_valid      <= '0;
      r_idx        <= '0;
      r_ltag       <= '0;
      r_cnt        <= '0;
      r_flush_pend <= 1'b0;
      r_mm_addr    <= '0;
      r_busy       <= 1'b0;
      r_hit_cnt    <= '0;
      r_miss_cnt   <= '0;
    end else begin
      if (w_hit && (r_hit_cnt != '1)) r_hit_cnt <= r_hit_cnt + CNT_WIDTH'(1);
      case (r_state)
        S_IDLE: begin
          if (FLUSH) begin
            r_valid <= '0;
          end else if (w_start) begin
            r_state        <= S_FILL;
            r_busy         <= 1'b1;
            r_mm_addr      <= {MEM_ADDR1[ADDR_WIDTH-1:c_OFF], {c_OFF{1'b0}}};
            r_idx          <= w_idx;
            r_ltag         <= w_tag;
            r_valid[w_idx] <= 1'b0;
            r_cnt          <= '0;
            r_flush_pend   <= 1'b0;
            if (r_miss_cnt != '1) r_miss_cnt <= r_miss_cnt + CNT_WIDTH'(1);
          end
        end
        S_FILL: begin
          if (FLUSH) r_flush_pend <= 1'b1;
          if (mm_valid) begin
            r_cnt <= r_cnt + c_OFF'(1);
            if (r_cnt == c_LAST) begin
              r_state      <= S_IDLE;
              r_busy       <= 1'b0;
              r_flush_pend <= 1'b0;
              // A flush seen at any point of the fill, even on its last beat, wins.
              if (r_flush_pend || FLUSH) r_valid <= '0;
              else                       r_valid[r_idx] <= 1'b1;
            end else begin
              r_mm_addr <= r_mm_addr + ADDR_WIDTH'(1);
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_icache_fill_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_icache_fill_ctrl
// Purpose  : Scoreboard bench for icache_fill_ctrl with a 3-cycle memory model.
// Revision : 1.0
// ============================================================================
module tb_icache_fill_ctrl;

  logic        clk = 1'b0;
  logic        rst, rden, flush;
  logic [13:0] addr;
  logic [31:0] dout;
  logic        mvalid, busy, mm_re;
  logic [13:0] mm_addr;
  logic [31:0] mm_data;
  logic        mm_valid;
  logic [3:0]  hit_cnt, miss_cnt;

  int          n_total = 0;
  int          n_bad   = 0;
  int          exp_hit = 0;
  int          exp_miss = 0;
  int          lat = 0;
  logic [31:0] sb[$];

  icache_fill_ctrl #(
    .ADDR_WIDTH(14), .LINE_WORDS(4), .NUM_LINES(16), .CNT_WIDTH(4)
  ) dut (
    .MEM_CLK(clk), .RST(rst), .MEM_RDEN1(rden), .MEM_ADDR1(addr), .FLUSH(flush),
    .MEM_DOUT1(dout), .memValid1(mvalid), .busy(busy), .mm_re(mm_re),
    .mm_addr(mm_addr), .mm_data(mm_data), .mm_valid(mm_valid),
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  always #5 clk = ~clk;

  // Main memory: answers each held address three cycles after it appears.
  always @(posedge clk) begin
    if (rst || !mm_re || mm_valid) begin
      lat      <= 0;
      mm_valid <= 1'b0;
    end else if (lat == 2) begin
      lat      <= 0;
      mm_valid <= 1'b1;
      mm_data  <= 32'hA000_0000 + 32'(mm_addr);
    end else begin
      lat      <= lat + 1;
      mm_valid <= 1'b0;
    end
  end

  function automatic int sat(input int v);
    return (v > 15) ? 15 : v;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic go_idle();
    @(posedge clk); #1;
    rden  = 1'b0;
    flush = 1'b0;
  endtask

  // Issues a request and holds it until the cache returns the word.
  task automatic do_read(input logic [13:0] a, input bit miss);
    int          cyc = 0;
    int          k = 0;
    bit          err = 0;
    bit          last_v = 0;
    logic [13:0] base;
    logic [31:0] e;
    base = {a[13:2], 2'b00};
    @(posedge clk); #1;
    rden = 1'b1;
    addr = a;
    sb.push_back(32'hA000_0000 + 32'(a));
    if (miss) exp_miss++;
    @(negedge clk);
    chk("hit_now", 32'(mvalid), 32'(!miss));
    chk("hit_cnt", 32'(hit_cnt), 32'(sat(exp_hit)));
    if (!miss) chk("mm_re_on_hit", 32'(mm_re), 32'd0);
    while (!mvalid && cyc < 200) begin
      if (dout !== 32'hDEAD_BEEF) err = 1;
      if (cyc > 0 && (!busy || !mm_re)) err = 1;
      if (mm_valid) begin
        chk("mm_addr", 32'(mm_addr), 32'(base + 14'(k)));
        k++;
      end
      last_v = mm_valid;
      @(negedge clk);
      cyc++;
    end
    if (!mvalid) begin
      chk("read_timeout", 32'd0, 32'd1);
      void'(sb.pop_front());
    end else begin
      e = sb.pop_front();
      chk("dout", dout, e);
      exp_hit++;
    end
    if (miss) begin
      chk("fill_words", 32'(k), 32'd4);
      chk("fill_flags", 32'(err), 32'd0);
      chk("hit_after_last", 32'(last_v), 32'd1);
    end
    chk("miss_cnt", 32'(miss_cnt), 32'(sat(exp_miss)));
  endtask

  initial begin
    int k;
    int cyc;
    rst = 1'b1; rden = 1'b0; flush = 1'b0; addr = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_mm_re", 32'(mm_re), 32'd0);
    chk("rst_mm_addr", 32'(mm_addr), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_valid", 32'(mvalid), 32'd0);
    chk("rst_dout", dout, 32'hDEAD_BEEF);
    chk("rst_hits", 32'(hit_cnt), 32'd0);
    chk("rst_miss", 32'(miss_cnt), 32'd0);

    // Cold miss, then the rest of the line hits back-to-back.
    do_read(14'h0010, 1);
    do_read(14'h0011, 0);
    do_read(14'h0012, 0);
    do_read(14'h0013, 0);
    go_idle();
    @(negedge clk);
    chk("hits_after_line", 32'(hit_cnt), 32'(sat(exp_hit)));

    // Same index, different tag: conflict misses both ways.
    do_read(14'h0410, 1);
    do_read(14'h0010, 1);
    go_idle();

    // Flush in IDLE suppresses the hit, starts no fill, and invalidates.
    @(posedge clk); #1;
    rden = 1'b1; addr = 14'h0010; flush = 1'b1;
    @(negedge clk);
    chk("flush_no_hit", 32'(mvalid), 32'd0);
    @(posedge clk); #1;
    flush = 1'b0; rden = 1'b0;
    @(negedge clk);
    chk("flush_no_fill", 32'(mm_re), 32'd0);
    do_read(14'h0010, 1);
    go_idle();

    // Flush mid-fill: fill completes but the line stays invalid.
    @(posedge clk); #1;
    rden = 1'b1; addr = 14'h0020; exp_miss++;
    @(posedge clk); #1;
    rden = 1'b0; addr = '0;
    repeat (2) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
    k = 0; cyc = 0;
    @(negedge clk);
    while (busy && cyc < 200) begin
      if (mm_valid) k++;
      @(negedge clk);
      cyc++;
    end
    chk("flush_fill_words", 32'(k), 32'd4);
    chk("flush_fill_done", 32'(busy), 32'd0);
    do_read(14'h0020, 1);
    go_idle();

    // Reset after two words of a fill.
    @(posedge clk); #1;
    rden = 1'b1; addr = 14'h0030;
    @(posedge clk); #1;
    rden = 1'b0;
    k = 0; cyc = 0;
    while (k < 2 && cyc < 200) begin
      @(negedge clk);
      if (mm_valid) k++;
      cyc++;
    end
    chk("pre_rst_words", 32'(k), 32'd2);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    exp_hit = 0; exp_miss = 0;
    @(negedge clk);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_mm_re", 32'(mm_re), 32'd0);
    chk("midrst_mm_addr", 32'(mm_addr), 32'd0);
    chk("midrst_hits", 32'(hit_cnt), 32'd0);
    chk("midrst_miss", 32'(miss_cnt), 32'd0);
    do_read(14'h0010, 1);

    // Twenty further hit cycles saturate the 4-bit hit counter.
    for (int i = 0; i < 20; i++) do_read(14'h0010, 0);
    go_idle();
    @(negedge clk);
    chk("hit_sat", 32'(hit_cnt), 32'hF);

    // Sixteen more conflict misses saturate the miss counter.
    for (int t = 1; t <= 16; t++) do_read({4'(t), 4'h4, 2'b00}, 1);
    go_idle();
    @(negedge clk);
    chk("miss_sat", 32'(miss_cnt), 32'hF);
    chk("hit_sat_hold", 32'(hit_cnt), 32'hF);
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

endmodule
`default_nettype wire
